lc3b_mem_ctrl: RTL and testbench
================================

# lc3b_mem_ctrl

Memory controller between the LC-3b multicycle CPU's memory port and a single-port synchronous word SRAM. It accepts the CPU's hold-until-response requests (`mem_read`/`mem_write` held high until `mem_resp`), inserts a configurable number of wait states, and issues exactly one SRAM access per request. It returns a one-cycle `mem_resp` with read data stable in that same cycle, which is the cycle in which the CPU loads MDR.

## Interface
Parameters:
- `WAIT_STATES`, default 2: idle cycles between request acceptance and the SRAM access. Legal range 0–15.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_address` in 16: CPU byte address (`lc3b_word`). Bit 0 is ignored.
- `mem_read` in 1: CPU read request, level.
- `mem_write` in 1: CPU write request, level.
- `mem_byte_enable` in 2: write byte mask (`lc3b_mem_wmask`). [0] selects the low byte, [1] the high byte.
- `mem_wdata` in 16: CPU write data.
- `mem_rdata` out 16: read data. Valid while `mem_resp`=1.
- `mem_resp` out 1: one-cycle completion pulse.
- `sram_addr` out 15: SRAM word address.
- `sram_ce` out 1: SRAM access strobe.
- `sram_we` out 1: SRAM write, qualified by `sram_ce`.
- `sram_be` out 2: SRAM byte enables.
- `sram_wdata` out 16: SRAM write data.
- `sram_rdata` in 16: SRAM read data. Valid the cycle after `sram_ce`=1 with `sram_we`=0.

## Operation
- The FSM has the states IDLE, WAIT, ISSUE, CAPTURE, RESPOND and RECOVER.
- IDLE:
  - If `mem_read | mem_write`, latch `addr_q`=`mem_address[15:1]`, `wdata_q`, `be_q` and `wr_q`.
  - If both request signals are high, the request is a write (`wr_q`=1).
  - Load `cnt`=`WAIT_STATES`. Go to WAIT, or go to ISSUE if `WAIT_STATES`=0.
- WAIT: decrement `cnt`. When `cnt`==1, go to ISSUE. The controller stays in WAIT for exactly `WAIT_STATES` cycles.
- ISSUE:
  - `sram_ce`=1 and `sram_we`=`wr_q`.
  - `sram_be`=`be_q` for a write, 2'b11 for a read.
  - A write with `be_q`=2'b00 drives `sram_ce`=0; no access is made, but the request still completes.
  - Go to CAPTURE.
- CAPTURE: for a read, `rdata_q` <= `sram_rdata`. For a write, `rdata_q` is unchanged. Go to RESPOND.
- RESPOND: `mem_resp`=1. Go to RECOVER.
- RECOVER:
  - Requests are ignored, because the CPU still shows its previous request this cycle.
  - Go to IDLE.
- Outputs:
  - `mem_rdata`=`rdata_q` at all times.
  - `sram_addr`=`addr_q` and `sram_wdata`=`wdata_q` at all times.
  - `sram_ce`, `sram_we` and `sram_be` are 0 outside ISSUE.
- Request inputs are sampled only in IDLE. Changes or deassertion in any other state have no effect; the latched transaction completes and `mem_resp` still pulses.

## Timing
- Reset values, effective after the reset edge:
  - state IDLE, `cnt`=0
  - `mem_resp`=0, `mem_rdata`=16'h0000
  - `sram_addr`=0, `sram_wdata`=0
  - `sram_ce`=0, `sram_we`=0, `sram_be`=2'b00
- Let cycle 0 be the IDLE cycle in which a request is seen:
  - ISSUE occurs in cycle `WAIT_STATES`+1.
  - CAPTURE occurs in cycle `WAIT_STATES`+2.
  - `mem_resp` is high in cycle `WAIT_STATES`+3 only.
  - RECOVER occurs in cycle `WAIT_STATES`+4.
  - The earliest next acceptance is cycle `WAIT_STATES`+5.
- Read and write latency are identical.
- `mem_resp` is never high for two consecutive cycles.
- There is exactly one ISSUE cycle per accepted request, so no SRAM access is duplicated.
- Reset during any state forces IDLE at that edge:
  - The partial transaction is discarded and no `mem_resp` is produced.
  - If reset is asserted during ISSUE, that cycle's SRAM strobe has already been driven. No further strobe follows.
- Reset takes priority over a request sampled in the same cycle.
- Back-to-back CPU requests (for example fetch followed by an LDR read) are each accepted only after RECOVER.

## Test plan
- Read, `WAIT_STATES`=2, SRAM word 0x1234 at word 0x0100, `mem_read`=1 with `mem_address`=0x0200:
  - `sram_ce`=1, `sram_we`=0 and `sram_addr`=0x0100 in cycle 3.
  - `mem_resp`=1 and `mem_rdata`=0x1234 in cycle 5 only.
- Write byte, `mem_write`=1, `mem_address`=0x0201, `mem_byte_enable`=2'b01, `mem_wdata`=0xBEEF:
  - A single ISSUE with `sram_be`=2'b01 and `sram_addr`=0x0100.
  - The SRAM low byte becomes 0xEF and the high byte is unchanged.
  - `mem_resp` pulses once.
- `WAIT_STATES`=0, request held continuously for 20 cycles: each accepted request gives ISSUE in cycle 1 and `mem_resp` in cycle 3. Because RECOVER blocks re-acceptance, the held request produces one SRAM access per 5 cycles.
- `mem_read` and `mem_write` both high: the transaction is a write (`sram_we`=1) and `mem_rdata` keeps its previous value.
- Reset asserted in the first WAIT cycle of a write:
  - The FSM is in IDLE next cycle and all outputs are at their reset values.
  - No `sram_ce` occurs and no `mem_resp` occurs.
- Write with `mem_byte_enable`=2'b00: `sram_ce` stays 0 throughout, `mem_resp` still pulses in cycle `WAIT_STATES`+3, and SRAM contents are unchanged.

Source files
------------

// File: rtl/lc3b_mem_ctrl_if.sv
// Purpose: bundle of the LC-3b CPU memory-port and word-SRAM signals served by lc3b_mem_ctrl.
// Latency: n/a (wires only).
// Backpressure: the CPU holds mem_read/mem_write until mem_resp; the SRAM side has no stall.
// Ports: mem_* = CPU side (byte address, level requests, byte mask, data, one-cycle resp);
//        sram_* = SRAM side (word address, strobe, write, byte enables, data in/out).
interface lc3b_mem_ctrl_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    logic [14:0] sram_addr;
    logic        sram_ce;
    logic        sram_we;
    logic [1:0]  sram_be;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    // Controller side.
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, sram_rdata,
        output mem_rdata, mem_resp, sram_addr, sram_ce, sram_we, sram_be, sram_wdata
    );

    // CPU / SRAM-model side.
    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, sram_rdata,
        input  mem_rdata, mem_resp, sram_addr, sram_ce, sram_we, sram_be, sram_wdata
    );
endinterface

// File: rtl/lc3b_mem_ctrl.sv
// Purpose: LC-3b CPU memory port to single-port synchronous word SRAM, one SRAM access per request.
// Latency: mem_resp in cycle WAIT_STATES+3 after the accepting IDLE cycle; next accept at +5.
// Backpressure: CPU holds its request until mem_resp; requests are only sampled in IDLE.
// Ports: clk, reset (sync, active-high), bus (lc3b_mem_ctrl_if.slave: mem_* CPU side, sram_* SRAM side).
module lc3b_mem_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    lc3b_mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_RESPOND,
        S_RECOVER
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;

    logic        sram_ce;
    logic        sram_we;
    logic [1:0]  sram_be;
    logic        mem_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 15'd0;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            wr_q    <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        sram_ce  = 1'b0;
        sram_we  = 1'b0;
        sram_be  = 2'b00;
        mem_resp = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    addr_d  = bus.mem_address[15:1];
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    // A write wins when both request lines are up.
                    wr_d    = bus.mem_write;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ISSUE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A write with no bytes enabled makes no access but still completes.
                if (!(wr_q && (be_q == 2'b00))) begin
                    sram_ce = 1'b1;
                    sram_we = wr_q;
                    sram_be = wr_q ? be_q : 2'b11;
                end
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // SRAM read data is registered, so it is valid the cycle after the strobe.
                if (!wr_q) begin
                    rdata_d = bus.sram_rdata;
                end
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                mem_resp = 1'b1;
                state_d  = S_RECOVER;
            end
            S_RECOVER: begin
                // The CPU still presents the request it just completed; ignore it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_resp   = mem_resp;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_ce    = sram_ce;
    assign bus.sram_we    = sram_we;
    assign bus.sram_be    = sram_be;

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Purpose: directed self-checking bench for lc3b_mem_ctrl with WAIT_STATES=2 and WAIT_STATES=0.
// Latency: n/a.
// Backpressure: bench holds requests until after mem_resp, like the CPU.
module tb_lc3b_mem_ctrl;

    logic clk;
    logic reset;

    int compared = 0;
    int mismatched = 0;

    lc3b_mem_ctrl_if bus_a ();
    lc3b_mem_ctrl_if bus_b ();

    lc3b_mem_ctrl #(.WAIT_STATES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    lc3b_mem_ctrl #(.WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM models with registered read data.
    logic [15:0] mem_a [0:32767];
    logic [15:0] mem_b [0:32767];
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    int ce_cnt_a = 0;
    int ce_cnt_b = 0;

    always @(posedge clk) begin
        if (bus_a.sram_ce) begin
            ce_cnt_a <= ce_cnt_a + 1;
            if (bus_a.sram_we) begin
                if (bus_a.sram_be[0]) mem_a[bus_a.sram_addr][7:0]  <= bus_a.sram_wdata[7:0];
                if (bus_a.sram_be[1]) mem_a[bus_a.sram_addr][15:8] <= bus_a.sram_wdata[15:8];
            end else begin
                rd_a <= mem_a[bus_a.sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (bus_b.sram_ce) begin
            ce_cnt_b <= ce_cnt_b + 1;
            if (bus_b.sram_we) begin
                if (bus_b.sram_be[0]) mem_b[bus_b.sram_addr][7:0]  <= bus_b.sram_wdata[7:0];
                if (bus_b.sram_be[1]) mem_b[bus_b.sram_addr][15:8] <= bus_b.sram_wdata[15:8];
            end else begin
                rd_b <= mem_b[bus_b.sram_addr];
            end
        end
    end

    assign bus_a.sram_rdata = rd_a;
    assign bus_b.sram_rdata = rd_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        compared++;
        assert (obs === req) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    // One request on dut_a, starting in the current (IDLE) cycle = cycle 0, held through RECOVER.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd,
                          input logic exp_ce, input logic [1:0] exp_be, input logic [15:0] exp_rdata);
        int ce0;
        ce0 = ce_cnt_a;
        bus_a.mem_read        = rd;
        bus_a.mem_write       = wr;
        bus_a.mem_address     = addr;
        bus_a.mem_byte_enable = be;
        bus_a.mem_wdata       = wd;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("%s ce c%0d", tag, c), 16'(bus_a.sram_ce), (c == 3) ? 16'(exp_ce) : 16'h0);
            chk($sformatf("%s resp c%0d", tag, c), 16'(bus_a.mem_resp), (c == 5) ? 16'h1 : 16'h0);
            if (c == 3) begin
                chk($sformatf("%s we", tag), 16'(bus_a.sram_we), 16'(wr & exp_ce));
                chk($sformatf("%s be", tag), 16'(bus_a.sram_be), 16'(exp_be));
                chk($sformatf("%s addr", tag), 16'(bus_a.sram_addr), 16'(addr[15:1]));
                if (wr) chk($sformatf("%s wdata", tag), bus_a.sram_wdata, wd);
            end
            if (c == 5) chk($sformatf("%s rdata", tag), bus_a.mem_rdata, exp_rdata);
            if (c == 6) begin
                bus_a.mem_read  = 1'b0;
                bus_a.mem_write = 1'b0;
            end
            tick();
        end
        chk($sformatf("%s strobes", tag), 16'(ce_cnt_a - ce0), 16'(exp_ce));
    endtask

    initial begin
        int ce0;
        reset = 1'b1;
        bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.mem_address = 16'h0;
        bus_a.mem_byte_enable = 2'b00; bus_a.mem_wdata = 16'h0;
        bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.mem_address = 16'h0;
        bus_b.mem_byte_enable = 2'b00; bus_b.mem_wdata = 16'h0;
        tick();
        tick();

        // Reset state.
        chk("rst resp",  16'(bus_a.mem_resp), 16'h0);
        chk("rst rdata", bus_a.mem_rdata, 16'h0000);
        chk("rst addr",  16'(bus_a.sram_addr), 16'h0);
        chk("rst wdata", bus_a.sram_wdata, 16'h0);
        chk("rst ce",    16'(bus_a.sram_ce), 16'h0);
        chk("rst we",    16'(bus_a.sram_we), 16'h0);
        chk("rst be",    16'(bus_a.sram_be), 16'h0);
        chk("rst b resp", 16'(bus_b.mem_resp), 16'h0);
        reset = 1'b0;
        tick();

        // Preload word 0x0100 = 0x1234 through the controller, then read it back.
        do_req("wr_full", 1'b0, 1'b1, 16'h0200, 2'b11, 16'h1234, 1'b1, 2'b11, 16'h0000);
        do_req("rd_1234", 1'b1, 1'b0, 16'h0200, 2'b00, 16'h0000, 1'b1, 2'b11, 16'h1234);
        // Low-byte write at odd byte address: bit 0 ignored, only low byte changes.
        do_req("wr_byte", 1'b0, 1'b1, 16'h0201, 2'b01, 16'hBEEF, 1'b1, 2'b01, 16'h1234);
        do_req("rd_12ef", 1'b1, 1'b0, 16'h0200, 2'b00, 16'h0000, 1'b1, 2'b11, 16'h12EF);
        // Read and write together: treated as a write, rdata keeps its value.
        do_req("rd_wr",   1'b1, 1'b1, 16'h0400, 2'b11, 16'hCAFE, 1'b1, 2'b11, 16'h12EF);
        do_req("rd_cafe", 1'b1, 1'b0, 16'h0400, 2'b00, 16'h0000, 1'b1, 2'b11, 16'hCAFE);
        // Empty byte mask: no strobe, response still pulses, contents untouched.
        do_req("wr_be00", 1'b0, 1'b1, 16'h0200, 2'b00, 16'h5555, 1'b0, 2'b00, 16'hCAFE);
        do_req("rd_keep", 1'b1, 1'b0, 16'h0200, 2'b00, 16'h0000, 1'b1, 2'b11, 16'h12EF);

        // Reset in the first WAIT cycle of a write, with the request still high.
        ce0 = ce_cnt_a;
        bus_a.mem_write = 1'b1; bus_a.mem_address = 16'h0600;
        bus_a.mem_byte_enable = 2'b11; bus_a.mem_wdata = 16'h7777;
        tick();
        reset = 1'b1;
        tick();
        chk("wrst resp",  16'(bus_a.mem_resp), 16'h0);
        chk("wrst rdata", bus_a.mem_rdata, 16'h0000);
        chk("wrst addr",  16'(bus_a.sram_addr), 16'h0);
        chk("wrst wdata", bus_a.sram_wdata, 16'h0);
        chk("wrst ce",    16'(bus_a.sram_ce), 16'h0);
        chk("wrst we",    16'(bus_a.sram_we), 16'h0);
        chk("wrst be",    16'(bus_a.sram_be), 16'h0);
        reset = 1'b0;
        bus_a.mem_write = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("wrst ce after c%0d", c), 16'(bus_a.sram_ce), 16'h0);
            chk($sformatf("wrst resp after c%0d", c), 16'(bus_a.mem_resp), 16'h0);
        end
        chk("wrst strobes", 16'(ce_cnt_a - ce0), 16'h0);

        // WAIT_STATES=0 with a write held for 20 cycles: one access every 5 cycles.
        ce0 = ce_cnt_b;
        bus_b.mem_write = 1'b1; bus_b.mem_address = 16'h0300;
        bus_b.mem_byte_enable = 2'b11; bus_b.mem_wdata = 16'hA5A5;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("hold ce c%0d", c), 16'(bus_b.sram_ce), ((c % 5) == 1) ? 16'h1 : 16'h0);
            chk($sformatf("hold resp c%0d", c), 16'(bus_b.mem_resp), ((c % 5) == 3) ? 16'h1 : 16'h0);
            tick();
        end
        bus_b.mem_write = 1'b0;
        chk("hold strobes", 16'(ce_cnt_b - ce0), 16'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
